// File: rtl/jedro_1_lsu.sv
// Load/store unit: one outstanding bus transfer, lane steering for byte/half/word, load write-back.
// Optional JEDRO_1_MISALIGN_TRAP_EN: trap misaligned requests instead of silently aligning them.
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      ctrl_valid_i,
    output logic                      ctrl_ready_o,
    input  logic                      ctrl_we_i,
    input  logic [1:0]                ctrl_size_i,
    input  logic                      ctrl_unsigned_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_addr_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_rd_i,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0]     rf_data_o,
    output logic                      rf_we_o,
    output logic                      bus_req_o,
    output logic                      bus_we_o,
    output logic [DATA_WIDTH-1:0]     bus_addr_o,
    output logic [3:0]                bus_be_o,
    output logic [DATA_WIDTH-1:0]     bus_wdata_o,
    input  logic                      bus_ack_i,
    input  logic [DATA_WIDTH-1:0]     bus_rdata_i,
    output logic                      busy_o,
    output logic                      misaligned_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [1:0]                state_q, state_d;
    logic                      we_q, we_d;
    logic [1:0]                size_q, size_d;
    logic                      uns_q, uns_d;
    logic [1:0]                off_q, off_d;
    logic [DATA_WIDTH-1:0]     addr_q, addr_d;
    logic [3:0]                be_q, be_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;
    logic                      mis_q, mis_d;

    logic [1:0]                req_off;
    logic [3:0]                req_be;
    logic [DATA_WIDTH-1:0]     req_wdata;

    // Select the addressed lane and extend it to the full register width.
    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [1:0]            size,
        input logic [1:0]            off,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] sh;
        logic signed [7:0]     b;
        logic signed [15:0]    h;
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            SZ_BYTE: load_ext = uns ? {{(DATA_WIDTH-8){1'b0}}, b}  : {{(DATA_WIDTH-8){b[7]}}, b};
            SZ_HALF: load_ext = uns ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
            default: load_ext = rdata;
        endcase
    endfunction

    always_comb begin
        req_off   = 2'b00;
        req_be    = 4'b1111;
        req_wdata = ctrl_wdata_i;
        case (ctrl_size_i)
            SZ_BYTE: begin
                req_off   = ctrl_addr_i[1:0];
                req_be    = 4'b0001 << ctrl_addr_i[1:0];
                req_wdata = {(DATA_WIDTH/8){ctrl_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                req_off   = {ctrl_addr_i[1], 1'b0};
                req_be    = 4'b0011 << {ctrl_addr_i[1], 1'b0};
                req_wdata = {(DATA_WIDTH/16){ctrl_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef JEDRO_1_MISALIGN_TRAP_EN
    logic req_mis;
    always_comb begin
        case (ctrl_size_i)
            SZ_BYTE: req_mis = 1'b0;
            SZ_HALF: req_mis = ctrl_addr_i[0];
            default: req_mis = (ctrl_addr_i[1:0] != 2'b00);
        endcase
    end
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        off_d     = off_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        rf_data_d = rf_data_q;
        mis_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_valid_i) begin
                    we_d    = ctrl_we_i;
                    size_d  = ctrl_size_i;
                    uns_d   = ctrl_unsigned_i;
                    off_d   = req_off;
                    addr_d  = {ctrl_addr_i[DATA_WIDTH-1:2], 2'b00};
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    rd_d    = ctrl_rd_i;
`ifdef JEDRO_1_MISALIGN_TRAP_EN
                    // A trapped request is consumed here and never reaches the bus.
                    if (req_mis) mis_d = 1'b1;
                    else         state_d = BUS;
`else
                    state_d = BUS;
`endif
                end
            end
            BUS: begin
                if (bus_ack_i) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        rf_data_d = load_ext(bus_rdata_i, size_q, off_q, uns_q);
                        state_d   = WB;
                    end
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 2'b00;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            rd_q      <= '0;
            rf_data_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            rf_data_q <= rf_data_d;
            mis_q     <= mis_d;
        end
    end

    // Ready is masked by reset so every output reads 0 while rstn_i is low.
    assign ctrl_ready_o = (state_q == IDLE) && rstn_i;
    assign busy_o       = (state_q != IDLE);
    assign bus_req_o    = (state_q == BUS);
    assign bus_we_o     = we_q;
    assign bus_addr_o   = addr_q;
    assign bus_be_o     = be_q;
    assign bus_wdata_o  = wdata_q;
    assign rf_addr_o    = rd_q;
    assign rf_data_o    = rf_data_q;
    assign rf_we_o      = (state_q == WB) && (rd_q != '0);
    assign misaligned_o = mis_q;

endmodule
